// File: rtl/car_types_pkg.sv
// Shared types for the crossing: lane counters, light encoding and the
// scheduler's state and lane-select enums.
package car_types_pkg;

  // Waiting-car count per lane, 0..10.
  localparam int CAR_COUNT_MAX = 10;
  typedef logic [3:0] car_counter_t;

  // Light driven into each car_lane.
  typedef enum logic [1:0] {
    RED    = 2'd0,
    YELLOW = 2'd1,
    GREEN  = 2'd2
  } strafic_light_t;

  // Scheduler phase, also exported for debug.
  typedef enum logic [2:0] {
    ALL_RED  = 3'd0,
    GREEN_A  = 3'd1,
    YELLOW_A = 3'd2,
    GREEN_B  = 3'd3,
    YELLOW_B = 3'd4
  } sched_state_t;

  // Lane preference for the next green.
  typedef enum logic {
    LANE_A = 1'b0,
    LANE_B = 1'b1
  } lane_sel_t;

  // Largest of three phase lengths; sizes the shared phase timer.
  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/traffic_light_scheduler_phase_timer.sv
// Saturating up-counter with synchronous clear. Counts cycles spent in the
// current scheduler phase; the FSM does all threshold compares.
module phase_timer #(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] SAT   = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Clear wins; otherwise count up and stick at SAT so it never wraps.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (count_q != SAT) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/traffic_light_scheduler.sv
// Two-lane crossing scheduler. Moore FSM choosing which lane gets GREEN from
// the lane car counts, with min/max green, fixed yellow, all-red clearance
// and an all-red hold request. Lights decode the state register directly.
module traffic_light_scheduler
  import car_types_pkg::*;
#(
  parameter int MIN_GREEN    = 4,
  parameter int MAX_GREEN    = 8,
  parameter int YELLOW_TIME  = 2,
  parameter int ALL_RED_TIME = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  car_counter_t   car_count_a,
  input  car_counter_t   car_count_b,
  input  logic           hold_all_red,
  output strafic_light_t light_a,
  output strafic_light_t light_b,
  output sched_state_t   phase
);

  // Timer only needs to reach the longest threshold, then it saturates.
  localparam int TMAX = max3(MAX_GREEN, YELLOW_TIME, ALL_RED_TIME);
  localparam int TW   = $clog2(TMAX) + 1;
  localparam logic [TW-1:0] T_SAT = TW'(TMAX - 1);

  sched_state_t    state_q, state_d;
  lane_sel_t       next_lane_q, next_lane_d;
  logic [TW-1:0]   timer_q;
  logic            timer_clr;
  logic            a_busy, b_busy;
  logic            pref_busy, other_busy;
  int              t;

  assign a_busy     = (car_count_a != '0);
  assign b_busy     = (car_count_b != '0);
  assign pref_busy  = (next_lane_q == LANE_A) ? a_busy : b_busy;
  assign other_busy = (next_lane_q == LANE_A) ? b_busy : a_busy;
  assign t          = int'(timer_q);

  // Timer restarts on every state change.
  assign timer_clr = (state_d != state_q);

  phase_timer #(
    .WIDTH (TW),
    .SAT   (T_SAT)
  ) u_phase_timer (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (timer_clr),
    .count_o (timer_q)
  );

  // Next-state and next-lane selection.
  always_comb begin
    state_d     = state_q;
    next_lane_d = next_lane_q;
    unique case (state_q)
      ALL_RED: begin
        if (t >= ALL_RED_TIME - 1 && !hold_all_red) begin
          if (pref_busy) begin
            state_d = (next_lane_q == LANE_A) ? GREEN_A : GREEN_B;
          end else if (other_busy) begin
            state_d = (next_lane_q == LANE_A) ? GREEN_B : GREEN_A;
          end
        end
      end
      GREEN_A: begin
        if (hold_all_red || (t >= MIN_GREEN - 1 && !a_busy) ||
            (t >= MAX_GREEN - 1 && b_busy)) begin
          state_d = YELLOW_A;
        end
      end
      YELLOW_A: begin
        if (t == YELLOW_TIME - 1) begin
          state_d     = ALL_RED;
          next_lane_d = LANE_B;
        end
      end
      GREEN_B: begin
        if (hold_all_red || (t >= MIN_GREEN - 1 && !b_busy) ||
            (t >= MAX_GREEN - 1 && a_busy)) begin
          state_d = YELLOW_B;
        end
      end
      YELLOW_B: begin
        if (t == YELLOW_TIME - 1) begin
          state_d     = ALL_RED;
          next_lane_d = LANE_A;
        end
      end
      default: begin
        state_d = ALL_RED;
      end
    endcase
  end

  // State and lane-preference registers; reset drops any lane straight to RED.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ALL_RED;
      next_lane_q <= LANE_A;
    end else begin
      state_q     <= state_d;
      next_lane_q <= next_lane_d;
    end
  end

  // Light decode from the current state only.
  always_comb begin
    light_a = RED;
    light_b = RED;
    unique case (state_q)
      GREEN_A:  light_a = GREEN;
      YELLOW_A: light_a = YELLOW;
      GREEN_B:  light_b = GREEN;
      YELLOW_B: light_b = YELLOW;
      default: begin
        light_a = RED;
        light_b = RED;
      end
    endcase
  end

  assign phase = state_q;

endmodule

// File: tb/tb_traffic_light_scheduler.sv
// Bench for traffic_light_scheduler: directed scenarios plus random traffic,
// compared every cycle against a phase/age reference model.
module tb_traffic_light_scheduler;
  import car_types_pkg::*;

  localparam int MIN_G = 4;
  localparam int MAX_G = 8;
  localparam int YEL   = 2;
  localparam int ALLR  = 1;

  logic           clk = 1'b0;
  logic           rst;
  car_counter_t   car_count_a, car_count_b;
  logic           hold_all_red;
  strafic_light_t light_a, light_b;
  sched_state_t   phase;

  always #5 clk = ~clk;

  traffic_light_scheduler #(
    .MIN_GREEN(MIN_G), .MAX_GREEN(MAX_G), .YELLOW_TIME(YEL), .ALL_RED_TIME(ALLR)
  ) dut (
    .clk(clk), .rst(rst), .car_count_a(car_count_a), .car_count_b(car_count_b),
    .hold_all_red(hold_all_red), .light_a(light_a), .light_b(light_b), .phase(phase)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: what the crossing is doing (0 all red, 1 green, 2 yellow),
  // which lane owns it, how many cycles it has lasted, preferred lane.
  int m_mode = 0, m_lane = 0, m_age = 0, m_pref = 0;

  // Run-length tracking of the observed phase.
  int prev_ph = 0, cur_len = 0;
  int last_len [5];

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_update(input bit r, input int ca, input int cb, input bit h);
    int cnt [2];
    int old_mode, old_lane, done;
    cnt[0] = ca; cnt[1] = cb;
    old_mode = m_mode; old_lane = m_lane;
    if (r) begin
      m_mode = 0; m_age = 0; m_pref = 0;
      return;
    end
    done = m_age + 1;  // cycles completed in this phase, including this one
    if (m_mode == 0) begin
      if (done >= ALLR && !h) begin
        if (cnt[m_pref] > 0) begin m_mode = 1; m_lane = m_pref; end
        else if (cnt[1 - m_pref] > 0) begin m_mode = 1; m_lane = 1 - m_pref; end
      end
    end else if (m_mode == 1) begin
      if (h || (done >= MIN_G && cnt[m_lane] == 0) || (done >= MAX_G && cnt[1 - m_lane] > 0))
        m_mode = 2;
    end else begin
      if (done == YEL) begin m_mode = 0; m_pref = 1 - m_lane; end
    end
    if (m_mode != old_mode || m_lane != old_lane) m_age = 0;
    else m_age++;
  endfunction

  function automatic int exp_light(input int lane);
    if (m_mode == 0 || m_lane != lane) return int'(RED);
    return (m_mode == 1) ? int'(GREEN) : int'(YELLOW);
  endfunction

  function automatic int exp_phase();
    if (m_mode == 0) return int'(ALL_RED);
    if (m_lane == 0) return (m_mode == 1) ? int'(GREEN_A) : int'(YELLOW_A);
    return (m_mode == 1) ? int'(GREEN_B) : int'(YELLOW_B);
  endfunction

  task automatic compare_all();
    check_val("light_a", int'(light_a), exp_light(0));
    check_val("light_b", int'(light_b), exp_light(1));
    check_val("phase", int'(phase), exp_phase());
    check_val("exclusive", int'(light_a != RED && light_b != RED), 0);
    if (int'(phase) == prev_ph) cur_len++;
    else begin
      last_len[prev_ph] = cur_len;
      prev_ph = int'(phase);
      cur_len = 1;
    end
  endtask

  // One clock: drive on the falling edge, advance model at the rising edge,
  // compare just after it.
  task automatic step(input bit r, input int ca, input int cb, input bit h);
    @(negedge clk);
    rst = r; car_count_a = car_counter_t'(ca); car_count_b = car_counter_t'(cb); hold_all_red = h;
    @(posedge clk);
    model_update(r, ca, cb, h);
    #1;
    compare_all();
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 0, 0, 1'b0);
  endtask

  int ca_r, cb_r, hold_left, guard;

  initial begin
    for (int i = 0; i < 5; i++) last_len[i] = 0;
    rst = 1'b1; car_count_a = '0; car_count_b = '0; hold_all_red = 1'b0;

    // Reset then idle.
    do_reset(3);
    check_val("reset_phase", int'(phase), int'(ALL_RED));
    for (int i = 0; i < 20; i++) step(1'b0, 0, 0, 1'b0);
    check_val("idle_phase", int'(phase), int'(ALL_RED));

    // Single lane, A empties at green cycle 6; then B preferred.
    do_reset(1);
    for (int i = 0; i < 6; i++) step(1'b0, 3, 0, 1'b0);
    check_val("single_green", int'(light_a), int'(GREEN));
    for (int i = 0; i < 6; i++) step(1'b0, 0, 0, 1'b0);
    check_val("single_yel_len", last_len[int'(YELLOW_A)], YEL);
    step(1'b0, 2, 2, 1'b0);
    check_val("next_lane_b", int'(phase), int'(GREEN_B));

    // Min green: count drops after the first green cycle.
    do_reset(1);
    step(1'b0, 1, 0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 0, 0, 1'b0);
    check_val("min_green_len", last_len[int'(GREEN_A)], MIN_G);

    // Max green handover with both lanes busy.
    do_reset(1);
    for (int i = 0; i < 50; i++) step(1'b0, 10, 5, 1'b0);
    check_val("max_green_a", last_len[int'(GREEN_A)], MAX_G);
    check_val("max_green_b", last_len[int'(GREEN_B)], MAX_G);
    check_val("yellow_a_len", last_len[int'(YELLOW_A)], YEL);
    check_val("all_red_len", last_len[int'(ALL_RED)], ALLR);

    // Reset during GREEN_A drops light_a straight to RED.
    guard = 0;
    while (phase != GREEN_A && guard < 40) begin step(1'b0, 10, 5, 1'b0); guard++; end
    check_val("wait_green_a", int'(guard < 40), 1);
    step(1'b1, 10, 5, 1'b0);
    check_val("rst_mid_green", int'(light_a), int'(RED));

    // No handover when the other lane is empty.
    do_reset(1);
    for (int i = 0; i < MAX_G + 31; i++) step(1'b0, 10, 0, 1'b0);
    check_val("no_handover", int'(phase), int'(GREEN_A));

    // Hold at GREEN_B cycle 1.
    do_reset(1);
    guard = 0;
    while (phase != GREEN_B && guard < 40) begin step(1'b0, 10, 5, 1'b0); guard++; end
    check_val("wait_green_b", int'(guard < 40), 1);
    step(1'b0, 10, 5, 1'b1);
    check_val("hold_yellow", int'(phase), int'(YELLOW_B));
    for (int i = 0; i < 10; i++) step(1'b0, 10, 5, 1'b1);
    check_val("hold_all_red", int'(phase), int'(ALL_RED));
    step(1'b0, 2, 0, 1'b0);
    check_val("release_green", int'(phase), int'(GREEN_A));

    // Random traffic with occasional holds and resets.
    do_reset(1);
    ca_r = 0; cb_r = 0; hold_left = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) ca_r = $urandom_range(0, CAR_COUNT_MAX);
      if ($urandom_range(0, 3) == 0) cb_r = $urandom_range(0, CAR_COUNT_MAX);
      if ($urandom_range(0, 6) == 0) begin
        if ($urandom_range(0, 1) == 0) ca_r = 0; else cb_r = 0;
      end
      if (hold_left > 0) hold_left--;
      else if ($urandom_range(0, 40) == 0) hold_left = $urandom_range(1, 12);
      step(($urandom_range(0, 499) == 0), ca_r, cb_r, (hold_left > 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/traffic_light_scheduler.md
# traffic_light_scheduler

- Sequences the traffic lights for a two-lane crossing: lane A and lane B, one car_lane instance each.
- Decides which lane gets GREEN from the two lanes' car counters.
- Enforces minimum and maximum green time, a fixed yellow phase and an all-red clearance phase.
- Supports an all-red hold request.
- Sits above the two car_lane instances; its light outputs drive their strafic_light inputs directly.

## Interface
Parameters:
- MIN_GREEN, default 4: minimum cycles a lane stays GREEN (≥1), unless hold_all_red is asserted.
- MAX_GREEN, default 8: cycles after which GREEN is handed over if the other lane waits (≥MIN_GREEN).
- YELLOW_TIME, default 2: cycles in YELLOW (≥1).
- ALL_RED_TIME, default 1: minimum cycles both lanes are RED between greens (≥1).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- car_count_a  in  car_counter_t  lane A waiting cars (0..10)
- car_count_b  in  car_counter_t  lane B waiting cars (0..10)
- hold_all_red  in  1  force both lanes to RED as soon as legally possible; hold there while high
- light_a  out  strafic_light_t  lane A light
- light_b  out  strafic_light_t  lane B light
- phase  out  sched_state_t  current scheduler state (debug/verification)

## Operation
- Moore FSM: ALL_RED, GREEN_A, YELLOW_A, GREEN_B, YELLOW_B.
- Registers:
  - next_lane: 1 bit, A=0, B=1; the lane preferred at the next green.
  - timer: cycles spent in the current state. Cleared on every state change. Increments otherwise, saturating at max(MAX_GREEN, YELLOW_TIME, ALL_RED_TIME)−1. Width is $clog2 of that maximum +1; it never wraps.
- ALL_RED: both lights RED. Leaves only when timer ≥ ALL_RED_TIME−1 and hold_all_red=0:
  - next_lane count >0 → GREEN of next_lane.
  - else other lane count >0 → GREEN of other lane.
  - else stay in ALL_RED (idle); next_lane unchanged.
- GREEN_X: light_X=GREEN, other light RED. Go to YELLOW_X when any of:
  - hold_all_red=1 (immediate, ignores MIN_GREEN).
  - timer ≥ MIN_GREEN−1 and own count =0.
  - timer ≥ MAX_GREEN−1 and other count >0.
- Own count >0 and other count =0: GREEN holds indefinitely past MAX_GREEN.
- YELLOW_X: light_X=YELLOW, other light RED. When timer = YELLOW_TIME−1, go to ALL_RED and set next_lane = other lane. hold_all_red has no effect here; yellow always runs its full length.
- Both lanes are never non-RED in the same cycle.
- Reset mid-phase: the next state is ALL_RED with both lights RED. A lane in GREEN or YELLOW at the reset edge drops straight to RED without a yellow phase.

## Timing
- Reset values:
  - state=ALL_RED, timer=0, next_lane=A.
  - light_a=RED, light_b=RED, phase=ALL_RED.
- Outputs decode the state register combinationally: no extra register stage, and a light changes in the same cycle the state changes.
- Counts and hold_all_red are sampled at each rising edge. A change in count affects the state after one edge.
- Phase durations:
  - Each ALL_RED lasts ≥ ALL_RED_TIME cycles.
  - GREEN lasts ≥ MIN_GREEN cycles, except under hold.
  - GREEN lasts exactly MAX_GREEN cycles when both lanes stay busy.
  - YELLOW lasts exactly YELLOW_TIME cycles.
- Simultaneous events: if own count reaches 0 and the other lane becomes non-empty in the same cycle, it is a single exit to YELLOW (no priority ambiguity).
- car_lane decrements only while its light is GREEN. A cross pulse during YELLOW is ignored by design.

## Structure
- Add to car_types_pkg:
  - sched_state_t enum (ALL_RED, GREEN_A, YELLOW_A, GREEN_B, YELLOW_B).
  - lane_sel_t (LANE_A, LANE_B).
- Reuse the existing strafic_light_t and car_counter_t.
- One natural sub-module: phase_timer.
  - Saturating up-counter with synchronous clear, parameterised by width.
  - Exposes the count; the FSM does the compares.
- A top-level crossing wrapper instantiates two car_lane instances plus this block. The wrapper is outside this block's scope.

## Test plan
All scenarios use defaults (MIN 4, MAX 8, YELLOW 2, ALL_RED 1).
- Reset then idle: rst high 3 cycles, both counts 0 → both RED, phase=ALL_RED held for 20 cycles. rst high mid-GREEN_A → light_a RED the cycle after the reset edge.
- Single lane: count_a=3, count_b=0 from reset release → GREEN_A after 1 ALL_RED cycle. count_a drops to 0 at green cycle 6 → YELLOW_A 2 cycles, then ALL_RED with next_lane=B.
- Min green: count_a=1 and drops to 0 in green cycle 1 → GREEN_A still lasts exactly 4 cycles.
- Max green handover: count_a=10, count_b=5, both constant → GREEN_A exactly 8 cycles, YELLOW_A 2, ALL_RED 1, GREEN_B 8. Pattern repeats with period 22. Both lights never non-RED together.
- No handover when the other lane is empty: count_a=10, count_b=0 → GREEN_A held 30 cycles past MAX.
- Hold: hold_all_red=1 at GREEN_B cycle 1 → YELLOW_B next cycle, 2 cycles, then ALL_RED held while hold=1. Release with count_a=2 → GREEN_A after ≥1 ALL_RED cycle.
